// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary-entry game: FSM states,
// active-low seven-segment patterns (a = bit 0), LFSR taps and small helpers.
package binary_game_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 -> register bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Folds a raw 7-bit LFSR slice into the 0..99 target range.
    function automatic logic [6:0] fold_target(input logic [6:0] raw);
        return (raw >= 7'd100) ? raw - 7'd100 : raw;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = value;
        for (int k = 0; k < 9; k++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rest)};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/binary_game_seg7_scan.sv
// Four-digit multiplexed seven-segment scanner: refresh divider, digit index,
// per-digit blanking and registered active-low anode/segment outputs.
module seg7_scan
    import binary_game_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0][3:0] digits,
    input  logic [3:0]      blank,
    output logic [3:0]      an,
    output logic [6:0]      seg
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] refresh_reg;
    logic [1:0]    digit_idx_reg;
    logic [3:0]    an_reg;
    logic [3:0]    an_next;
    logic [6:0]    seg_reg;
    logic [6:0]    seg_next;

    // A blanked digit keeps its anode off, so at most one anode is ever low.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = !((digit_idx_reg == 2'(gi)) && !blank[gi]);
        end
    endgenerate

    always_comb begin
        seg_next = SEG_BLANK;
        if (!blank[digit_idx_reg]) begin
            seg_next = seg_encode(digits[digit_idx_reg]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg   <= '0;
            digit_idx_reg <= 2'd0;
            an_reg        <= 4'hF;
            seg_reg       <= SEG_BLANK;
        end else begin
            if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
                refresh_reg   <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: rtl/binary_game.sv
// Game core: button synchronizer/edge detect, LFSR target generator, round
// timer, score keeping and PLAY/OVER FSM driving the multiplexed display.
module binary_game
    import binary_game_pkg::*;
#(
    parameter int         REFRESH_DIV = 100_000,
    parameter int         SEC_DIV     = 100_000_000,
    parameter int         ROUND_SECS  = 10,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW     = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam int SECS_W = $clog2(ROUND_SECS + 1);

    state_t            state_reg, state_next;
    logic [7:0]        lfsr_reg;
    logic [6:0]        score_reg, score_next;
    logic [6:0]        target_reg, target_next;
    logic [CW-1:0]     cyc_reg, cyc_next;
    logic [SECS_W-1:0] secs_reg, secs_next;
    logic              btn_sync1_reg, btn_sync2_reg, btn_prev_reg;
    logic              press;
    logic              timeout;
    logic [6:0]        new_target;
    logic [7:0]        score_bcd, target_bcd;
    logic              unused_sw7;

    assign unused_sw7 = sw[7];
    assign press      = btn_sync2_reg && !btn_prev_reg;
    assign new_target = fold_target(lfsr_reg[6:0]);
    // Fires on the last cycle of the final second so OVER lands exactly on time.
    assign timeout    = (secs_reg == SECS_W'(ROUND_SECS - 1)) && (cyc_reg == CW'(SEC_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync1_reg <= 1'b0;
            btn_sync2_reg <= 1'b0;
            btn_prev_reg  <= 1'b0;
            lfsr_reg      <= LFSR_SEED;
            state_reg     <= PLAY;
            score_reg     <= 7'd0;
            target_reg    <= fold_target(LFSR_SEED[6:0]);
            cyc_reg       <= '0;
            secs_reg      <= '0;
        end else begin
            btn_sync1_reg <= btn;
            btn_sync2_reg <= btn_sync1_reg;
            btn_prev_reg  <= btn_sync2_reg;
            lfsr_reg      <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
            state_reg     <= state_next;
            score_reg     <= score_next;
            target_reg    <= target_next;
            cyc_reg       <= cyc_next;
            secs_reg      <= secs_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        score_next  = score_reg;
        target_next = target_reg;
        cyc_next    = cyc_reg;
        secs_next   = secs_reg;
        case (state_reg)
            PLAY: begin
                if (cyc_reg == CW'(SEC_DIV - 1)) begin
                    cyc_next  = '0;
                    secs_next = secs_reg + 1'b1;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
                // A press in the timeout cycle wins over the timeout.
                if (press) begin
                    if (sw[6:0] == target_reg) begin
                        score_next  = (score_reg == 7'd99) ? score_reg : score_reg + 7'd1;
                        target_next = new_target;
                        cyc_next    = '0;
                        secs_next   = '0;
                    end else begin
                        state_next = OVER;
                    end
                end else if (timeout) begin
                    state_next = OVER;
                end
            end
            OVER: begin
                if (press) begin
                    state_next  = PLAY;
                    score_next  = 7'd0;
                    target_next = new_target;
                    cyc_next    = '0;
                    secs_next   = '0;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    assign score_bcd  = to_bcd(score_reg);
    assign target_bcd = to_bcd(target_reg);

    seg7_scan #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .digits ({score_bcd[7:4], score_bcd[3:0], target_bcd[7:4], target_bcd[3:0]}),
        .blank  ((state_reg == OVER) ? 4'b0011 : 4'b0000),
        .an     (an),
        .seg    (seg)
    );

endmodule

// File: tb/tb_binary_game.sv
// Directed testbench for binary_game with a short refresh/second/round setup.
module tb_binary_game;
    import binary_game_pkg::*;

    localparam int RD = 4;
    localparam int SD = 10;
    localparam int RS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] sw  = 8'd0;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [6:0] cur_target;
    logic [6:0] dig_seg [4];
    int         dig_cnt [4];
    int         blank_cnt;
    int         bad_an;

    binary_game #(
        .REFRESH_DIV(RD),
        .SEC_DIV    (SD),
        .ROUND_SECS (RS),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .btn (btn),
        .an  (an),
        .seg (seg)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [6:0] model_target(input logic [7:0] l);
        logic [6:0] t;
        t = l[6:0];
        return (t >= 7'd100) ? t - 7'd100 : t;
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle button pulse; returns at the negedge after the update edge.
    task automatic press_once(input logic [7:0] value);
        sw  = value;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic scan_display();
        for (int i = 0; i < 4; i++) begin
            dig_seg[i] = 7'h7F;
            dig_cnt[i] = 0;
        end
        blank_cnt = 0;
        bad_an    = 0;
        for (int c = 0; c < 4 * RD; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin dig_seg[0] = seg; dig_cnt[0]++; end
                4'b1101: begin dig_seg[1] = seg; dig_cnt[1]++; end
                4'b1011: begin dig_seg[2] = seg; dig_cnt[2]++; end
                4'b0111: begin dig_seg[3] = seg; dig_cnt[3]++; end
                4'b1111: begin blank_cnt++; if (seg !== 7'h7F) bad_an++; end
                default: bad_an++;
            endcase
        end
    endtask

    task automatic test_reset();
        int exp_d [4];
        exp_d = '{7, 3, 0, 0};
        do_reset();
        $display("reset released");
        @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_first_an: got %b expected %b", an, 4'b1110); end
        checks++; if (seg !== 7'b1111000) begin errors++; $display("FAIL reset_first_seg: got %b expected %b", seg, 7'b1111000); end
        checks++; if (dut.state_reg !== PLAY) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_reg, PLAY); end
        scan_display();
        checks++; if (bad_an !== 0 || blank_cnt !== 0) begin errors++; $display("FAIL reset_onehot: got bad=%0d blank=%0d expected 0 0", bad_an, blank_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dig_seg[i] !== exp_seg(exp_d[i]) || dig_cnt[i] !== RD) begin
                errors++;
                $display("FAIL reset_digit%0d: got seg=%b cnt=%0d expected seg=%b cnt=%0d", i, dig_seg[i], dig_cnt[i], exp_seg(exp_d[i]), RD);
            end
        end
    endtask

    task automatic test_correct_submit();
        logic [6:0] exp_t;
        do_reset();
        sw  = 8'd37;
        btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dut.score_reg !== 7'd0) begin errors++; $display("FAIL correct_early: got %0d expected 0", dut.score_reg); end
        exp_t = model_target(m_lfsr);
        @(negedge clk);
        checks++; if (dut.score_reg !== 7'd1) begin errors++; $display("FAIL correct_score: got %0d expected 1", dut.score_reg); end
        checks++; if (dut.target_reg !== exp_t) begin errors++; $display("FAIL correct_target: got %0d expected %0d", dut.target_reg, exp_t); end
        checks++; if (dut.target_reg > 7'd99) begin errors++; $display("FAIL correct_range: got %0d expected <=99", dut.target_reg); end
        btn = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (dut.score_reg !== 7'd1) begin errors++; $display("FAIL correct_hold: got %0d expected 1", dut.score_reg); end
        $display("correct submit: score %0d target %0d", dut.score_reg, exp_t);
        cur_target = exp_t;
        scan_display();
        checks++; if (dig_seg[3] !== exp_seg(0) || dig_seg[2] !== exp_seg(1)) begin errors++; $display("FAIL correct_disp_score: got %b %b expected %b %b", dig_seg[3], dig_seg[2], exp_seg(0), exp_seg(1)); end
        checks++; if (dig_seg[1] !== exp_seg(int'(exp_t) / 10) || dig_seg[0] !== exp_seg(int'(exp_t) % 10)) begin errors++; $display("FAIL correct_disp_target: got %b %b for target %0d", dig_seg[1], dig_seg[0], exp_t); end
    endtask

    task automatic test_wrong_submit();
        logic [6:0] exp_t;
        press_once({1'b0, cur_target ^ 7'h01});
        $display("wrong submit: state %0d score %0d", dut.state_reg, dut.score_reg);
        checks++; if (dut.state_reg !== OVER) begin errors++; $display("FAIL wrong_state: got %0d expected %0d", dut.state_reg, OVER); end
        checks++; if (dut.score_reg !== 7'd1) begin errors++; $display("FAIL wrong_score_held: got %0d expected 1", dut.score_reg); end
        sw = 8'd37;
        scan_display();
        checks++; if (blank_cnt !== 2 * RD || bad_an !== 0) begin errors++; $display("FAIL wrong_blank: got blank=%0d bad=%0d expected %0d 0", blank_cnt, bad_an, 2 * RD); end
        checks++; if (dig_cnt[1] !== 0 || dig_cnt[0] !== 0) begin errors++; $display("FAIL wrong_target_lit: got %0d %0d expected 0 0", dig_cnt[1], dig_cnt[0]); end
        checks++; if (dig_seg[3] !== exp_seg(0) || dig_seg[2] !== exp_seg(1)) begin errors++; $display("FAIL wrong_disp_score: got %b %b expected %b %b", dig_seg[3], dig_seg[2], exp_seg(0), exp_seg(1)); end
        checks++; if (dut.state_reg !== OVER || dut.score_reg !== 7'd1) begin errors++; $display("FAIL wrong_frozen: got state=%0d score=%0d expected %0d 1", dut.state_reg, dut.score_reg, OVER); end
        sw  = 8'hFF;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        exp_t = model_target(m_lfsr);
        @(negedge clk);
        $display("restart: state %0d score %0d target %0d", dut.state_reg, dut.score_reg, dut.target_reg);
        checks++; if (dut.state_reg !== PLAY) begin errors++; $display("FAIL restart_state: got %0d expected %0d", dut.state_reg, PLAY); end
        checks++; if (dut.score_reg !== 7'd0) begin errors++; $display("FAIL restart_score: got %0d expected 0", dut.score_reg); end
        checks++; if (dut.target_reg !== exp_t) begin errors++; $display("FAIL restart_target: got %0d expected %0d", dut.target_reg, exp_t); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (RS * SD - 1) @(negedge clk);
        checks++; if (dut.state_reg !== PLAY) begin errors++; $display("FAIL timeout_early: got %0d expected %0d", dut.state_reg, PLAY); end
        @(negedge clk);
        $display("timeout: state %0d after %0d cycles", dut.state_reg, RS * SD);
        checks++; if (dut.state_reg !== OVER) begin errors++; $display("FAIL timeout_exact: got %0d expected %0d", dut.state_reg, OVER); end
        do_reset();
        sw = 8'd37;
        repeat (RS * SD - 3) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        checks++; if (dut.score_reg !== 7'd0) begin errors++; $display("FAIL timeout_press_early: got %0d expected 0", dut.score_reg); end
        @(negedge clk);
        $display("timeout with press: state %0d score %0d", dut.state_reg, dut.score_reg);
        checks++; if (dut.state_reg !== PLAY || dut.score_reg !== 7'd1) begin errors++; $display("FAIL timeout_press: got state=%0d score=%0d expected %0d 1", dut.state_reg, dut.score_reg, PLAY); end
        @(negedge clk);
        checks++; if (dut.state_reg !== PLAY) begin errors++; $display("FAIL timeout_cleared: got %0d expected %0d", dut.state_reg, PLAY); end
    endtask

    task automatic test_saturation();
        int exp_s;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            press_once({1'b1, dut.target_reg});
            exp_s = (i + 1 > 99) ? 99 : i + 1;
            checks++;
            if (dut.score_reg !== 7'(exp_s) || dut.state_reg !== PLAY) begin
                errors++;
                $display("FAIL sat_press%0d: got score=%0d state=%0d expected %0d %0d", i, dut.score_reg, dut.state_reg, exp_s, PLAY);
            end
        end
        $display("saturation: score %0d after 100 presses", dut.score_reg);
        scan_display();
        checks++; if (dig_seg[3] !== exp_seg(9) || dig_seg[2] !== exp_seg(9)) begin errors++; $display("FAIL sat_disp: got %b %b expected %b %b", dig_seg[3], dig_seg[2], exp_seg(9), exp_seg(9)); end
    endtask

    task automatic test_reset_mid_game();
        do_reset();
        for (int i = 0; i < 5; i++) press_once({1'b0, dut.target_reg});
        press_once({1'b0, dut.target_reg ^ 7'h01});
        checks++; if (dut.state_reg !== OVER || dut.score_reg !== 7'd5) begin errors++; $display("FAIL mid_setup: got state=%0d score=%0d expected %0d 5", dut.state_reg, dut.score_reg, OVER); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset mid-game: state %0d score %0d target %0d", dut.state_reg, dut.score_reg, dut.target_reg);
        checks++; if (dut.score_reg !== 7'd0) begin errors++; $display("FAIL mid_score: got %0d expected 0", dut.score_reg); end
        checks++; if (dut.state_reg !== PLAY) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut.state_reg, PLAY); end
        checks++; if (dut.target_reg !== 7'd37) begin errors++; $display("FAIL mid_target: got %0d expected 37", dut.target_reg); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct_submit();
        test_wrong_submit();
        test_timeout();
        test_saturation();
        test_reset_mid_game();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/binary_game.md
# binary_game

Single-player binary-entry game with a four-digit seven-segment display. A pseudo-random decimal target from 00 to 99 is shown. The player sets it in binary on `sw[6:0]` and presses `btn`. Correct entries score a point and draw a new target; a wrong entry or timeout ends the game. The block is the top-level core; it drives the board's multiplexed display directly.

## Interface
- `REFRESH_DIV`, 100_000: clock cycles each digit stays lit during scanning.
- `SEC_DIV`, 100_000_000: clock cycles per one-second tick.
- `ROUND_SECS`, 10: whole seconds allowed per target.
- `LFSR_SEED`, 8'hA5: LFSR value loaded at reset; must be nonzero.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sw` in 8: player entry. Only `sw[6:0]` is compared; `sw[7]` is ignored.
- `btn` in 1: submit/restart. It must be debounced upstream and is asynchronous to `clk`.
- `an` out 4: digit enables, active-low. `an[3]` is the leftmost digit.
- `seg` out 7: segment drives, active-low, with `seg[0]`=a through `seg[6]`=g.

## Operation
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It steps every cycle.
- **New target:** `t = lfsr[6:0]`. If `t >= 100`, use `t-100`. The result is always 0..99.
- **Button:** 2-flop synchronizer followed by a rising-edge detector, giving a one-cycle `press` pulse.
- **States:** `PLAY` and `OVER`.
- **PLAY, press with `sw[6:0] == target`:** score increments and saturates at 99. Draw a new target and clear the round timer.
- **PLAY, press with `sw[6:0] != target`:** go to `OVER`.
- **PLAY, round timer reaches `ROUND_SECS`:** go to `OVER`.
- **Press and timeout in the same cycle:** the press is evaluated; the timeout is ignored.
- **OVER:** score is held; `sw` is ignored. A press sets score to 0, draws a new target, clears the timer and returns to `PLAY`.
- **Round timer:** a cycle counter runs 0..`SEC_DIV`-1. At wrap, a seconds counter increments. Both counters clear on every new target. Both are frozen in `OVER`.
- **Display:** a 2-bit digit index advances every `REFRESH_DIV` cycles, wrapping 3→0.
  - Digit 3 shows the score tens; digit 2 the score ones.
  - Digit 1 shows the target tens; digit 0 the target ones.
  - Values are decimal, with leading zeros shown.
  - In `OVER`, digits 1 and 0 are blank (`an` bit high, `seg`=7'h7F).
- **Reset values:**
  - state `PLAY`, score 0, `lfsr`=`LFSR_SEED`, timers 0, digit index 0.
  - target derived from the seed: 8'hA5 gives 37.
  - First display cycle after reset: `an`=4'b1110, `seg`=7'b1111000 (digit "7").

## Timing
- `an` and `seg` are registered. They change one cycle after the digit index changes, and are never lit on two digits at once.
- **Press latency:** `btn` is sampled high at edge N. The `press` pulse is high between N+1 and N+2. Score, state and target update at edge N+2 and are visible on the display from the next scan of the affected digit.
- **Holding `btn`:** exactly one press is produced. Another press requires a low sample first.
- **Timeout:** with no press, `OVER` is entered exactly `ROUND_SECS*SEC_DIV` cycles after the target load.
- **Reset mid-game:** reset has priority over all events and restores the reset values at the next edge.

## Structure
- Package `binary_game_pkg` holds:
  - the state enum (`PLAY`, `OVER`);
  - seven-segment constants for digits 0-9 and blank (active-low, a=bit 0);
  - the LFSR tap mask.
- Sub-module `seg7_scan` contains:
  - the refresh counter and digit index;
  - 4-to-1 BCD selection with per-digit blank;
  - the decoder and output registers.
- The core (FSM, LFSR, timers, score and target in BCD or with binary-to-BCD for 0..99) stays in `binary_game`.

## Test plan
Parameters for all scenarios: `REFRESH_DIV`=4, `SEC_DIV`=10, `ROUND_SECS`=3.
- **Reset:** hold `rst` 2 cycles, then scan one full refresh period.
  - Digits read 0,0,3,7.
  - The first lit cycle has `an`=1110, `seg`=1111000.
  - Exactly one `an` bit is low at any time.
- **Correct submit:** `sw`=8'd37, pulse `btn` 3 cycles.
  - Score becomes 01 two edges after the first high sample.
  - The new target equals the LFSR-derived value and lies in 0..99.
  - Holding `btn` gives no second increment.
- **Wrong submit:** `sw`=8'd36 at the target 37, press.
  - State becomes `OVER` and the score is held.
  - Digits 1 and 0 are blank.
  - A second press gives score 00, a new target, and `PLAY`.
- **Timeout:** no presses after reset.
  - `OVER` is entered exactly 30 cycles after reset release.
  - A press landing in the timeout cycle is scored instead.
- **Saturation:** 99 consecutive correct presses (bench reads the target), then one more.
  - Score displays 99 and stays 99.
- **Reset mid-game:** assert `rst` in `OVER` with score 05.
  - After the next edge: score 00, state `PLAY`, target 37.
